// File: rtl/axis_channel_switcher.sv
// axis_channel_switcher: routes any of INPUT_CHANNELS sample streams to each DAC output (or mutes it),
// switching glitch-free either immediately or on a sync strobe, with zero-blanking of changed outputs.
module axis_channel_switcher #(
    parameter int PARALLEL_SAMPLES = 16,
    parameter int SAMPLE_WIDTH     = 16,
    parameter int INPUT_CHANNELS   = 24,
    parameter int OUTPUT_CHANNELS  = 8,
    parameter int BLANK_CYCLES     = 4,
    localparam int SEL_BITS        = $clog2(INPUT_CHANNELS + 1),
    localparam int DWIDTH          = PARALLEL_SAMPLES * SAMPLE_WIDTH,
    localparam int CFG_W           = 1 + SEL_BITS * OUTPUT_CHANNELS
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [INPUT_CHANNELS-1:0][DWIDTH-1:0]       data_in_data_i,
    input  logic [INPUT_CHANNELS-1:0]                   data_in_valid_i,
    output logic [OUTPUT_CHANNELS-1:0][DWIDTH-1:0]      data_out_data_o,
    output logic [OUTPUT_CHANNELS-1:0]                  data_out_valid_o,
    input  logic [CFG_W-1:0]                            config_data_i,
    input  logic                                        config_valid_i,
    output logic                                        config_ready_o,
    input  logic                                        sync_i,
    output logic                                        busy_o,
    output logic                                        switch_done_o
);
    localparam int CNT_W = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [SEL_BITS-1:0] MUTE = SEL_BITS'(INPUT_CHANNELS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT_SYNC, BLANK, APPLY} state_t;
    localparam state_t GO = BLANK_CYCLES == 0 ? APPLY : BLANK;

    state_t                                      state_q;
    logic [OUTPUT_CHANNELS-1:0][SEL_BITS-1:0]    active_q, pending_q, cfg_sel, eff_sel;
    logic [OUTPUT_CHANNELS-1:0]                  mask_q, changed;
    logic [CNT_W-1:0]                            cnt_q;
    logic                                        busy_q, done_q;
    logic [OUTPUT_CHANNELS-1:0][DWIDTH-1:0]      data_q, data_d;
    logic [OUTPUT_CHANNELS-1:0]                  valid_q, valid_d;

    // During APPLY the datapath already reads the pending map, so the new
    // source is visible at data_out in the cycle right after APPLY.
    always_comb begin
        cfg_sel = '0;
        changed = '0;
        eff_sel = '0;
        data_d  = '0;
        valid_d = '0;
        for (int i = 0; i < OUTPUT_CHANNELS; i++) begin
            cfg_sel[i] = config_data_i[1 + SEL_BITS*i +: SEL_BITS];
            changed[i] = (cfg_sel[i] >= MUTE && active_q[i] >= MUTE) ? 1'b0 : cfg_sel[i] != active_q[i];
            eff_sel[i] = state_q == APPLY ? pending_q[i] : active_q[i];
            valid_d[i] = eff_sel[i] < MUTE && data_in_valid_i[eff_sel[i]];
            data_d[i]  = (eff_sel[i] >= MUTE || (state_q == BLANK && mask_q[i])) ? '0
                                                                               : data_in_data_i[eff_sel[i]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            for (int i = 0; i < OUTPUT_CHANNELS; i++)
                active_q[i] <= i < INPUT_CHANNELS ? SEL_BITS'(i) : MUTE;
            pending_q <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: if (config_valid_i) begin
                    pending_q <= cfg_sel;
                    mask_q    <= changed;
                    cnt_q     <= '0;
                    busy_q    <= 1'b1;
                    state_q   <= config_data_i[0] ? WAIT_SYNC : GO;
                    done_q    <= !config_data_i[0] && BLANK_CYCLES == 0;
                end
                WAIT_SYNC: if (sync_i) begin
                    state_q <= GO;
                    done_q  <= BLANK_CYCLES == 0;
                end
                BLANK: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= APPLY;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    active_q <= pending_q;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign data_out_data_o  = data_q;
    assign data_out_valid_o = valid_q;
    assign config_ready_o   = state_q == IDLE;
    assign busy_o           = busy_q;
    assign switch_done_o    = done_q;
endmodule
